// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: sequencer state
// encoding, instruction class codes from the decoder, and small helpers.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_JUMP   = 3'd6,
    S_HALT   = 3'd7
  } seq_state_t;

  localparam logic [3:0] CLS_RALU   = 4'd0;
  localparam logic [3:0] CLS_IALU   = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_J      = 4'd5;
  localparam logic [3:0] CLS_JAL    = 4'd6;
  localparam logic [3:0] CLS_JR     = 4'd8;
  localparam logic [3:0] CLS_HALT   = 4'd15;

  // Width of the MEM wait timer; covers MEM_TIMEOUT up to 255.
  localparam int unsigned TIMER_W = 8;

  function automatic logic is_jump_class(input logic [3:0] cls);
    return (cls == CLS_J) || (cls == CLS_JAL) || (cls == CLS_JR);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Loadable down-counter used to bound the wait for mem_done.
// expired is high while the count sits at zero; the count holds at zero.
module seq_wait_timer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  // Load on MEM entry, then count down once per MEM cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multicycle instruction sequencer: owns the word-indexed PC and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB/JUMP with one-cycle stage
// enables and level-sensitive done handshakes.
// Optional: define SEQ_PERF_CNT_EN to add cycle_cnt/instr_cnt outputs.
module instr_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         MEM_TIMEOUT = 15,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          path_index,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                imem_ready,
  input  logic                alu_done,
  input  logic                mem_done,
  input  logic                jump_done,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                exec_en,
  output logic                mem_en,
  output logic                wb_en,
  output logic                jump_en,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                fault,
  output logic [2:0]          state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instr_cnt
`endif
);

  seq_state_t          cur, nxt;
  logic                first_q;     // high in the first cycle of every state visit
  logic [PC_WIDTH-1:0] pc_nxt, pc_inc;
  logic [3:0]          cls_q;
  logic                cls_ld;
  logic [PC_WIDTH-1:0] jtgt_q;
  logic                jtgt_ld;
  logic                fault_set;
  logic                tmr_load, tmr_expired;

  assign pc_inc = pc + PC_WIDTH'(1);

  seq_wait_timer u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TIMER_W'(MEM_TIMEOUT - 1)),
    .en       (cur == S_MEM),
    .expired  (tmr_expired)
  );

  // State, PC, latched class/target and sticky fault registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= S_IDLE;
      first_q <= 1'b0;
      pc      <= RESET_PC;
      cls_q   <= '0;
      jtgt_q  <= '0;
      fault   <= 1'b0;
    end else begin
      cur     <= nxt;
      first_q <= (nxt != cur);
      pc      <= pc_nxt;
      if (cls_ld)    cls_q  <= path_index;
      if (jtgt_ld)   jtgt_q <= jump_target;
      if (fault_set) fault  <= 1'b1;
    end
  end

  // Next state, PC update and stage enables; done flags count only after the pulse cycle.
  always_comb begin
    nxt       = cur;
    pc_nxt    = pc;
    cls_ld    = 1'b0;
    jtgt_ld   = 1'b0;
    fault_set = 1'b0;
    tmr_load  = 1'b0;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    jump_en   = 1'b0;
    case (cur)
      S_IDLE, S_HALT: begin
        if (start) nxt = S_FETCH;
      end
      S_FETCH: begin
        fetch_en = first_q;
        if (!first_q && imem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        decode_en = first_q;
        if (!first_q) begin
          cls_ld = 1'b1;
          if (path_index <= CLS_BRANCH) begin
            nxt = S_EXEC;
          end else if (is_jump_class(path_index)) begin
            nxt = S_JUMP;
          end else if (path_index == CLS_HALT) begin
            nxt = S_HALT;
          end else begin
            nxt    = S_FETCH;
            pc_nxt = pc_inc;
          end
        end
      end
      S_EXEC: begin
        exec_en = first_q;
        if (!first_q && alu_done) begin
          if ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) begin
            nxt      = S_MEM;
            tmr_load = 1'b1;
          end else if (cls_q == CLS_BRANCH) begin
            nxt    = S_FETCH;
            pc_nxt = branch_taken ? branch_target : pc_inc;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_MEM: begin
        mem_en = first_q;
        if (!first_q && mem_done) begin
          if (cls_q == CLS_STORE) begin
            nxt    = S_FETCH;
            pc_nxt = pc_inc;
          end else begin
            nxt = S_WB;
          end
        end else if (tmr_expired) begin
          fault_set = 1'b1;
          nxt       = S_HALT;
        end
      end
      S_WB: begin
        wb_en = first_q;
        if (!first_q) begin
          nxt    = S_FETCH;
          pc_nxt = (cls_q == CLS_JAL) ? jtgt_q : pc_inc;
        end
      end
      S_JUMP: begin
        jump_en = first_q;
        if (!first_q && jump_done) begin
          jtgt_ld = 1'b1;
          if (cls_q == CLS_JAL) begin
            nxt = S_WB;
          end else begin
            nxt    = S_FETCH;
            pc_nxt = jump_target;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign busy  = (cur != S_IDLE) && (cur != S_HALT);
  assign state = cur;

`ifdef SEQ_PERF_CNT_EN
  // Saturating performance counters: busy cycles and FETCH entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 32'd1;
      if ((nxt == S_FETCH) && (cur != S_FETCH) && (instr_cnt != '1))
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the stimulus queues expected stage
// pulses (kind, PC, cycle gap from previous pulse) and a decoder program;
// a monitor pops and compares on every enable pulse.
module tb_instr_sequencer;

  localparam int K_F = 0, K_D = 1, K_E = 2, K_M = 3, K_W = 4, K_J = 5;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  path_index;
  logic        branch_taken;
  logic [31:0] branch_target, jump_target;
  logic        imem_ready, alu_done, mem_done, jump_done;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, jump_en;
  logic [31:0] pc;
  logic        busy, fault;
  logic [2:0]  state;
  logic        mem_hold;

  always #5 clk = ~clk;

  instr_sequencer #(
    .PC_WIDTH    (32),
    .MEM_TIMEOUT (15),
    .RESET_PC    (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .path_index    (path_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .imem_ready    (imem_ready),
    .alu_done      (alu_done),
    .mem_done      (mem_done),
    .jump_done     (jump_done),
    .fetch_en      (fetch_en),
    .decode_en     (decode_en),
    .exec_en       (exec_en),
    .mem_en        (mem_en),
    .wb_en         (wb_en),
    .jump_en       (jump_en),
    .pc            (pc),
    .busy          (busy),
    .fault         (fault),
    .state         (state)
  );

  typedef struct {
    int          kind;
    logic [31:0] pc;
    int          gap;
  } exp_t;

  typedef struct {
    logic [3:0]  cls;
    logic        taken;
    logic [31:0] btgt;
    logic [31:0] jtgt;
  } prog_t;

  exp_t  exp_q[$];
  prog_t prog_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic ev(input int k, input logic [31:0] p, input int g);
    exp_t e;
    e.kind = k; e.pc = p; e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic prog(input logic [3:0] c, input logic t, input logic [31:0] bt, input logic [31:0] jt);
    prog_t p;
    p.cls = c; p.taken = t; p.btgt = bt; p.jtgt = jt;
    prog_q.push_back(p);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (busy && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached_busy", {31'd0, busy}, 32'd0);
    check("halt_state", {29'd0, state}, 32'd7);
    check("exp_drained", exp_q.size(), 32'd0);
  endtask

  task automatic wait_mem_pulse();
    int n;
    n = 0;
    while (!mem_en && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check("mem_pulse_seen", {31'd0, mem_en}, 32'd1);
  endtask

  // Monitor: every enable pulse pops one expectation.
  initial begin
    int cyc, last, kind;
    logic [5:0] en;
    exp_t e;
    cyc = 0; last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      en = {jump_en, wb_en, mem_en, exec_en, decode_en, fetch_en};
      if (en != 6'd0) begin
        check("pulse_onehot", $countones(en), 32'd1);
        kind = 0;
        for (int i = 5; i >= 0; i--) if (en[i]) kind = i;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual_kind=%0d pc=%h required=none", kind, pc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", kind, e.kind);
          check("pulse_pc", pc, e.pc);
          if (e.gap != 0) check("pulse_gap", cyc - last, e.gap);
        end
        last = cyc;
      end
    end
  end

  // Decoder model: presents the next programmed class on each decode pulse.
  initial begin
    prog_t p;
    forever begin
      @(negedge clk);
      if (decode_en) begin
        if (prog_q.size() > 0) begin
          p = prog_q.pop_front();
          path_index    = p.cls;
          branch_taken  = p.taken;
          branch_target = p.btgt;
          jump_target   = p.jtgt;
        end else begin
          path_index = 4'hF;
        end
      end
    end
  end

  // Stage units: raise done for one cycle, one cycle after each pulse.
  initial begin
    logic f, a, m, j;
    forever begin
      @(negedge clk);
      f = fetch_en; a = exec_en; m = mem_en; j = jump_en;
      @(posedge clk);
      #1;
      imem_ready = f;
      alu_done   = a;
      mem_done   = m && !mem_hold;
      jump_done  = j;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; path_index = 4'd0; branch_taken = 1'b0;
    branch_target = '0; jump_target = '0; mem_hold = 1'b0;
    imem_ready = 1'b0; alu_done = 1'b0; mem_done = 1'b0; jump_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_enables", {26'd0, jump_en, wb_en, mem_en, exec_en, decode_en, fetch_en}, 32'd0);
    rst = 1'b0;

    // R-ALU at pc 0: 8-cycle instruction, then halt at pc 1.
    prog(4'd0, 1'b0, 32'h0, 32'h0);
    ev(K_F, 32'h0, 0); ev(K_D, 32'h0, 2); ev(K_E, 32'h0, 2); ev(K_W, 32'h0, 2);
    ev(K_F, 32'h1, 2); ev(K_D, 32'h1, 2);
    do_start();
    wait_halt();
    check("ralu_pc", pc, 32'h1);

    // j to 0x40: 6-cycle instruction, no writeback.
    prog(4'd5, 1'b0, 32'h0, 32'h40);
    ev(K_F, 32'h1, 0); ev(K_D, 32'h1, 2); ev(K_J, 32'h1, 2);
    ev(K_F, 32'h40, 2); ev(K_D, 32'h40, 2);
    do_start();
    wait_halt();
    check("j_pc", pc, 32'h40);

    // j to 3, then jal 0x10 from pc 3: JUMP then WB, PC loads latched target.
    prog(4'd5, 1'b0, 32'h0, 32'h3);
    prog(4'd6, 1'b0, 32'h0, 32'h10);
    ev(K_F, 32'h40, 0); ev(K_D, 32'h40, 2); ev(K_J, 32'h40, 2);
    ev(K_F, 32'h3, 2); ev(K_D, 32'h3, 2); ev(K_J, 32'h3, 2); ev(K_W, 32'h3, 2);
    ev(K_F, 32'h10, 2); ev(K_D, 32'h10, 2);
    do_start();
    wait_halt();
    check("jal_pc", pc, 32'h10);

    // Taken branch to 0x20.
    prog(4'd4, 1'b1, 32'h20, 32'h0);
    ev(K_F, 32'h10, 0); ev(K_D, 32'h10, 2); ev(K_E, 32'h10, 2);
    ev(K_F, 32'h20, 2); ev(K_D, 32'h20, 2);
    do_start();
    wait_halt();
    check("br_taken_pc", pc, 32'h20);

    // j to 5, then not-taken branch: PC+1.
    prog(4'd5, 1'b0, 32'h0, 32'h5);
    prog(4'd4, 1'b0, 32'h77, 32'h0);
    ev(K_F, 32'h20, 0); ev(K_D, 32'h20, 2); ev(K_J, 32'h20, 2);
    ev(K_F, 32'h5, 2); ev(K_D, 32'h5, 2); ev(K_E, 32'h5, 2);
    ev(K_F, 32'h6, 2); ev(K_D, 32'h6, 2);
    do_start();
    wait_halt();
    check("br_nottaken_pc", pc, 32'h6);

    // load, store, unknown class (NOP), I-ALU.
    prog(4'd2, 1'b0, 32'h0, 32'h0);
    prog(4'd3, 1'b0, 32'h0, 32'h0);
    prog(4'd7, 1'b0, 32'h0, 32'h0);
    prog(4'd1, 1'b0, 32'h0, 32'h0);
    ev(K_F, 32'h6, 0); ev(K_D, 32'h6, 2); ev(K_E, 32'h6, 2); ev(K_M, 32'h6, 2); ev(K_W, 32'h6, 2);
    ev(K_F, 32'h7, 2); ev(K_D, 32'h7, 2); ev(K_E, 32'h7, 2); ev(K_M, 32'h7, 2);
    ev(K_F, 32'h8, 2); ev(K_D, 32'h8, 2);
    ev(K_F, 32'h9, 2); ev(K_D, 32'h9, 2); ev(K_E, 32'h9, 2); ev(K_W, 32'h9, 2);
    ev(K_F, 32'hA, 2); ev(K_D, 32'hA, 2);
    do_start();
    wait_halt();
    check("mix_pc", pc, 32'hA);

    // Load with mem_done held low: fault and HALT after the 15th MEM cycle.
    mem_hold = 1'b1;
    prog(4'd2, 1'b0, 32'h0, 32'h0);
    ev(K_F, 32'hA, 0); ev(K_D, 32'hA, 2); ev(K_E, 32'hA, 2); ev(K_M, 32'hA, 2);
    do_start();
    wait_mem_pulse();
    repeat (14) @(negedge clk);
    check("to_cycle15_state", {29'd0, state}, 32'd4);
    check("to_cycle15_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    check("to_state", {29'd0, state}, 32'd7);
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_pc", pc, 32'hA);
    check("to_drained", exp_q.size(), 32'd0);
    mem_hold = 1'b0;

    // Resume after fault: fault stays set.
    prog(4'd0, 1'b0, 32'h0, 32'h0);
    ev(K_F, 32'hA, 0); ev(K_D, 32'hA, 2); ev(K_E, 32'hA, 2); ev(K_W, 32'hA, 2);
    ev(K_F, 32'hB, 2); ev(K_D, 32'hB, 2);
    do_start();
    wait_halt();
    check("resume_pc", pc, 32'hB);
    check("resume_fault", {31'd0, fault}, 32'd1);

    // Async reset during MEM of a load.
    mem_hold = 1'b1;
    prog(4'd2, 1'b0, 32'h0, 32'h0);
    ev(K_F, 32'hB, 0); ev(K_D, 32'hB, 2); ev(K_E, 32'hB, 2); ev(K_M, 32'hB, 2);
    do_start();
    wait_mem_pulse();
    #2 rst = 1'b1;
    #1;
    check("arst_state", {29'd0, state}, 32'd0);
    check("arst_pc", pc, 32'd0);
    check("arst_enables", {26'd0, jump_en, wb_en, mem_en, exec_en, decode_en, fetch_en}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_fault", {31'd0, fault}, 32'd0);
    mem_hold = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_with_rst_ignored", {29'd0, state}, 32'd0);
    check("arst_drained", exp_q.size(), 32'd0);

    // j to all-ones, R-ALU there: PC wraps to 0.
    prog(4'd5, 1'b0, 32'h0, 32'hFFFF_FFFF);
    prog(4'd0, 1'b0, 32'h0, 32'h0);
    ev(K_F, 32'h0, 0); ev(K_D, 32'h0, 2); ev(K_J, 32'h0, 2);
    ev(K_F, 32'hFFFF_FFFF, 2); ev(K_D, 32'hFFFF_FFFF, 2); ev(K_E, 32'hFFFF_FFFF, 2);
    ev(K_W, 32'hFFFF_FFFF, 2); ev(K_F, 32'h0, 2); ev(K_D, 32'h0, 2);
    do_start();
    wait_halt();
    check("wrap_pc", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
